// File: rtl/gpio_in_ctrl.sv
// gpio_in_ctrl: memory-mapped controller for N_CH debounced board inputs.
// Each lane has a 2-FF synchroniser and a debounce counter. The top level
// adds sticky edge flags, a mode/irq config register and the bus read mux.

// One input lane: synchroniser plus debounce filter.
module gpio_in_lane #(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic raw,
    output logic level
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser; raw is the second stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            raw   <= 1'b0;
        end else begin
            sync1 <= din;
            raw   <= sync1;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (raw == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= raw;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module gpio_in_ctrl #(
    parameter int          N_CH      = 24,
    parameter int          DB_CYCLES = 20000,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F070
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [N_CH-1:0] din,
    output logic            irq
);
    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] edge_flags;
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] w1c;
    logic [2:0]      cfg;
    logic            sel;
    logic            wr_edge;
    logic            wr_cfg;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        gpio_in_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .din   (din[i]),
            .raw   (raw[i]),
            .level (level[i])
        );
    end

    assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_edge = we && sel && (addr[3:2] == 2'd1);
    assign wr_cfg  = we && sel && (addr[3:2] == 2'd2);

    // Edge events come from comparing the debounced level with last cycle's.
    always_comb begin
        ev  = '0;
        w1c = '0;
        unique case (cfg[1:0])
            2'b00:   ev = level & ~level_q;
            2'b01:   ev = ~level & level_q;
            default: ev = level ^ level_q;
        endcase
        if (wr_edge) w1c = wdata[N_CH-1:0];
    end

    // Flags, config and irq; a new event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= '0;
            edge_flags <= '0;
            cfg        <= '0;
            irq        <= 1'b0;
        end else begin
            level_q    <= level;
            edge_flags <= (edge_flags & ~w1c) | ev;
            if (wr_cfg) cfg <= wdata[2:0];
            irq        <= cfg[2] & (|edge_flags);
        end
    end

    // Read mux; unselected addresses read zero.
    always_comb begin
        rdata = '0;
        if (sel) begin
            unique case (addr[3:2])
                2'd0: rdata = 32'(level);
                2'd1: rdata = 32'(edge_flags);
                2'd2: rdata = 32'(cfg);
                2'd3: rdata = 32'(raw);
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{addr[1:0], wdata};
endmodule
